softmax_result_unpacker: RTL and testbench
==========================================

Name: softmax_result_unpacker

Overview:
- Consumer end of the pseudo-softmax output interface.
- Accepts one result vector: a shared mantissa plus one exponent per class.
- Converts each class to an unsigned fixed-point probability and streams the classes one per beat over a valid/ready handshake.
- Tracks the argmax and reports it when the vector completes; sits between the softmax core and the downstream classifier/readout logic.

Parameters:
- NUM_INPUTS, 4, number of classes per vector (>=2).
- EXP_WIDTH, 4, per-class exponent field width; the field is an unsigned right-shift count.
- MANT_WIDTH, 3, shared mantissa width (implicit leading 1 not stored).
- PROB_WIDTH, 8, output probability width, all fractional bits; PROB_WIDTH >= MANT_WIDTH+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  result vector present.
- in_ready  out  1  block can accept a vector.
- mant_in  in  MANT_WIDTH  shared mantissa.
- exp_in  in  NUM_INPUTS*EXP_WIDTH  class i exponent at exp_in[i*EXP_WIDTH +: EXP_WIDTH].
- out_valid  out  1  beat present.
- out_ready  in  1  downstream accepts the beat.
- out_index  out  IDX_WIDTH  class number of the current beat.
- out_prob  out  PROB_WIDTH  probability of the current class.
- out_last  out  1  current beat is class NUM_INPUTS-1.
- argmax  out  IDX_WIDTH  winning class of the last completed vector.
- argmax_valid  out  1  one-cycle pulse, argmax updated.

Behaviour:
- Reset is asynchronous, active-high (already decided).
- Reset values: state IDLE, index 0, out_valid 0, argmax 0, argmax_valid 0, captured registers 0.
- in_ready is forced 0 while rst is high.
- All outputs are decoded from registers only; there is no combinational path from any input to any output.

FSM IDLE:
- in_ready=1, out_valid=0.
- On in_valid&&in_ready: capture mant_in and exp_in, clear index, clear best_idx/best_exp, go STREAM.

FSM STREAM:
- in_ready=0; in_valid is ignored.
- out_valid=1, out_index=index, out_last=(index==NUM_INPUTS-1).
- Probability for class i: prob = ({1'b1,mant} << (PROB_WIDTH-1-MANT_WIDTH)) >> e_i, i.e. value 1.mant x 2^-(e_i+1).
- Any e_i >= PROB_WIDTH gives 0; truncation only, no rounding.
- Beats are held stable while out_valid && !out_ready.
- On handshake:
  - If index==0, or e_i < best_exp, then best_idx<=index and best_exp<=e_i. Ties keep the lower index.
  - Increment index.
- On the handshake of the last beat: argmax<=final best_idx, argmax_valid=1 in the next cycle only, go IDLE.

Timing and boundaries:
- First beat is visible the cycle after the input is accepted.
- Minimum period is NUM_INPUTS+1 cycles per vector.
- argmax holds its value until the next completed vector.
- Reset mid-STREAM: abort immediately; out_valid drops asynchronously, no argmax_valid pulse, argmax returns to 0.
- The index counter never wraps; the FSM leaves STREAM at NUM_INPUTS-1.

Decomposition:
- Shared package softmax_pkg holds:
  - The state enum {IDLE, STREAM}.
  - IDX_WIDTH = max(1, $clog2(NUM_INPUTS)).
  - The field-extraction helper for the exponent bus.
- One sub-module, softmax_prob_shifter: combinational (mant, exp) -> prob with the saturate-to-zero rule. It is reusable by the verification model.

Test Plan (all with defaults):
- Basic vector: mant=3'b010, exp e0=2, e1=1, e2=0, e3=3, out_ready=1 -> beats (0,0x28), (1,0x50), (2,0xA0), (3,0x14); out_last on beat 3; argmax_valid pulse with argmax=2.
- Backpressure: same vector, out_ready=0 for 3 cycles at beat 1 -> out_index=1 and out_prob=0x50 stable throughout; exactly 4 beats; same argmax.
- Underflow and ties: mant=3'b111, all exponents 8, then all 15 -> every out_prob=0x00; argmax=0 (lowest index on tie).
- Reset mid-stream: assert rst after beat 1 handshake -> out_valid=0 at once, no argmax_valid, argmax=0; after release in_ready=1 and the next vector streams from index 0.
- Input gating: in_valid held high with a second vector (mant=0, exp all 0) during STREAM -> ignored until IDLE, then accepted; beats all 0x80, argmax=0; exactly 2 argmax_valid pulses total.
- Back-to-back: continuous in_valid with out_ready=1 -> 5-cycle period per vector, no lost or duplicated beats across 8 vectors.

Source files
------------

// File: rtl/softmax_result_unpacker_pkg.sv
// Shared definitions for the softmax result unpacker: FSM states, index
// width helper and exponent bus field extraction.
package softmax_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Widest exponent bus the field helper can address.
  localparam int unsigned EXP_BUS_MAX = 256;

  // Class index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Extract field idx (w bits wide) from a packed exponent bus.
  function automatic logic [31:0] exp_field(input logic [EXP_BUS_MAX-1:0] bus,
                                            input int unsigned            idx,
                                            input int unsigned            w);
    logic [EXP_BUS_MAX-1:0] sh;
    sh = bus >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/softmax_result_unpacker_prob_shifter.sv
// Converts a shared mantissa and one exponent (right-shift count) into an
// unsigned all-fractional probability, 1.mant * 2^-(exp+1), truncated.
module softmax_prob_shifter #(
  parameter int unsigned EXP_WIDTH  = 4,
  parameter int unsigned MANT_WIDTH = 3,
  parameter int unsigned PROB_WIDTH = 8
) (
  input  logic [MANT_WIDTH-1:0] mant_i,
  input  logic [EXP_WIDTH-1:0]  exp_i,
  output logic [PROB_WIDTH-1:0] prob_o
);

  localparam int unsigned ALIGN = PROB_WIDTH - 1 - MANT_WIDTH;

  logic [PROB_WIDTH-1:0] aligned;

  // Place the implicit one at the MSB, then shift; large exponents underflow to zero.
  always_comb begin
    aligned = PROB_WIDTH'({1'b1, mant_i}) << ALIGN;
    if (32'(exp_i) >= PROB_WIDTH) begin
      prob_o = '0;
    end else begin
      prob_o = aligned >> exp_i;
    end
  end

endmodule

// File: rtl/softmax_result_unpacker.sv
// Consumer end of the pseudo-softmax output: captures one result vector,
// streams one probability beat per class and reports the argmax.
module softmax_result_unpacker
  import softmax_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned EXP_WIDTH  = 4,
  parameter int unsigned MANT_WIDTH = 3,
  parameter int unsigned PROB_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [MANT_WIDTH-1:0]              mant_in,
  input  logic [NUM_INPUTS*EXP_WIDTH-1:0]    exp_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [idx_width(NUM_INPUTS)-1:0]   out_index,
  output logic [PROB_WIDTH-1:0]              out_prob,
  output logic                               out_last,
  output logic [idx_width(NUM_INPUTS)-1:0]   argmax,
  output logic                               argmax_valid
);

  localparam int unsigned IDX_WIDTH = idx_width(NUM_INPUTS);
  localparam int unsigned EXP_BUS_W = NUM_INPUTS * EXP_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  state_t                 state_q;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic [IDX_WIDTH-1:0]   best_idx_q;
  logic [IDX_WIDTH-1:0]   argmax_q;
  logic                   argmax_valid_q;
  logic [MANT_WIDTH-1:0]  mant_q;
  logic [EXP_BUS_W-1:0]   exp_q;
  logic [EXP_WIDTH-1:0]   best_exp_q;

  logic [EXP_WIDTH-1:0]   cur_exp;
  logic                   is_last;
  logic                   take_cur;
  logic [IDX_WIDTH-1:0]   best_idx_d;
  logic [EXP_WIDTH-1:0]   best_exp_d;

  // Current class exponent and the running-best update (ties keep the lower index).
  always_comb begin
    cur_exp    = EXP_WIDTH'(exp_field(EXP_BUS_MAX'(exp_q), 32'(idx_q), EXP_WIDTH));
    is_last    = (idx_q == LAST_IDX);
    take_cur   = (idx_q == '0) || (cur_exp < best_exp_q);
    best_idx_d = take_cur ? idx_q   : best_idx_q;
    best_exp_d = take_cur ? cur_exp : best_exp_q;
  end

  softmax_prob_shifter #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH),
    .PROB_WIDTH (PROB_WIDTH)
  ) u_shifter (
    .mant_i (mant_q),
    .exp_i  (cur_exp),
    .prob_o (out_prob)
  );

  // Capture/stream FSM with the argmax result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      best_idx_q     <= '0;
      best_exp_q     <= '0;
      argmax_q       <= '0;
      argmax_valid_q <= 1'b0;
      mant_q         <= '0;
      exp_q          <= '0;
    end else begin
      argmax_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mant_q     <= mant_in;
            exp_q      <= exp_in;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_exp_q <= '0;
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            best_idx_q <= best_idx_d;
            best_exp_q <= best_exp_d;
            if (is_last) begin
              argmax_q       <= best_idx_d;
              argmax_valid_q <= 1'b1;
              state_q        <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; in_ready is also gated by reset.
  always_comb begin
    in_ready     = (state_q == IDLE) && !rst;
    out_valid    = (state_q == STREAM);
    out_index    = idx_q;
    out_last     = (state_q == STREAM) && is_last;
    argmax       = argmax_q;
    argmax_valid = argmax_valid_q;
  end

endmodule

// File: tb/tb_softmax_result_unpacker.sv
module tb_softmax_result_unpacker;

  localparam int unsigned N  = 4;
  localparam int unsigned EW = 4;
  localparam int unsigned MW = 3;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [MW-1:0]   mant_in;
  logic [N*EW-1:0] exp_in;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   out_index;
  logic [PW-1:0]   out_prob;
  logic            out_last;
  logic [IW-1:0]   argmax;
  logic            argmax_valid;

  typedef struct {
    int unsigned idx;
    int unsigned prob;
    bit          last;
  } beat_t;

  beat_t       exp_beats[$];
  int unsigned exp_argmax[$];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cycle = 0;
  int unsigned acc_count = 0;
  int unsigned beats_seen = 0;
  int unsigned pulses = 0;
  int unsigned exp_pulses = 0;
  int unsigned last_acc_cycle = 0;
  int unsigned held_argmax = 0;
  bit          b2b_mode = 1'b0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  softmax_result_unpacker #(
    .NUM_INPUTS (N),
    .EXP_WIDTH  (EW),
    .MANT_WIDTH (MW),
    .PROB_WIDTH (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mant_in      (mant_in),
    .exp_in       (exp_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_prob     (out_prob),
    .out_last     (out_last),
    .argmax       (argmax),
    .argmax_valid (argmax_valid)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Probability = 1.m * 2^-(e+1), expressed with PW fractional bits, truncated.
  function automatic int unsigned model_prob(input int unsigned m, input int unsigned e);
    longint unsigned num;
    longint unsigned den;
    num = (longint'(2 ** MW) + longint'(m)) * longint'(2 ** (PW - 1 - MW));
    den = longint'(1) << e;
    return 32'(num / den);
  endfunction

  // Largest probability = smallest exponent; first occurrence wins.
  function automatic int unsigned model_argmax(input logic [N*EW-1:0] bus);
    int unsigned best;
    int unsigned best_e;
    best   = 0;
    best_e = 32'(bus[EW-1:0]);
    for (int unsigned i = 1; i < N; i++) begin
      if (32'(bus[i*EW +: EW]) < best_e) begin
        best   = i;
        best_e = 32'(bus[i*EW +: EW]);
      end
    end
    return best;
  endfunction

  // Scoreboard push on input acceptance; pop and compare on output beats / pulses.
  always @(negedge clk) begin
    cycle++;
    if (!rst && in_valid && in_ready) begin
      for (int unsigned i = 0; i < N; i++) begin
        beat_t b;
        b.idx  = i;
        b.prob = model_prob(32'(mant_in), 32'(exp_in[i*EW +: EW]));
        b.last = (i == N - 1);
        exp_beats.push_back(b);
      end
      exp_argmax.push_back(model_argmax(exp_in));
      exp_pulses++;
      acc_count++;
      if (b2b_mode && last_acc_cycle != 0)
        check("b2b_period", cycle - last_acc_cycle, N + 1);
      last_acc_cycle = cycle;
    end
    if (!rst && out_valid) begin
      if (exp_beats.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        beat_t b;
        b = exp_beats[0];
        checks++;
        if (32'(out_index) != b.idx || 32'(out_prob) != b.prob || out_last != b.last) begin
          errors++;
          $display("FAIL beat: got idx=%0d prob=0x%02h last=%0b, required idx=%0d prob=0x%02h last=%0b",
                   out_index, out_prob, out_last, b.idx, b.prob, b.last);
        end
        if (out_ready) begin
          void'(exp_beats.pop_front());
          beats_seen++;
        end
      end
    end
    if (!rst && argmax_valid) begin
      pulses++;
      if (exp_argmax.size() == 0) begin
        fail_now("unexpected_argmax_pulse");
      end else begin
        held_argmax = exp_argmax.pop_front();
        check("argmax", 32'(argmax), held_argmax);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [MW-1:0] m, input logic [N*EW-1:0] e, input bit keep);
    int unsigned start;
    int unsigned n;
    start    = acc_count;
    mant_in  = m;
    exp_in   = e;
    in_valid = 1'b1;
    n = 0;
    while (acc_count == start && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (acc_count == start) begin
      fail_now("accept_timeout");
    end else begin
      check("first_beat_valid", 32'(out_valid), 1);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_argmax.size() != 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail_now("drain_timeout");
    @(posedge clk);
    #1;
    check("argmax_hold", 32'(argmax), held_argmax);
  endtask

  initial begin
    int unsigned base;
    int unsigned n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mant_in   = '0;
    exp_in    = '0;
    out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_argmax", 32'(argmax), 0);
    check("rst_argmax_valid", 32'(argmax_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 1);

    // Basic vector: e = {3,0,1,2} (class 3 .. class 0), mant 010.
    send(3'b010, 16'h3012, 1'b0);
    drain();

    // Backpressure on beat 1.
    base = beats_seen;
    send(3'b010, 16'h3012, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("stall_index", 32'(out_index), 1);
    check("stall_prob", 32'(out_prob), 32'h50);
    out_ready = 1'b1;
    drain();
    check("stall_beat_count", beats_seen - base, N);

    // Underflow and ties.
    send(3'b111, 16'h8888, 1'b0);
    drain();
    send(3'b111, 16'hFFFF, 1'b0);
    drain();

    // Reset mid-stream after beat 1 handshake.
    base = beats_seen;
    send(3'b010, 16'h3012, 1'b0);
    n = 0;
    while (beats_seen < base + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (beats_seen < base + 2) fail_now("midstream_wait");
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_argmax", 32'(argmax), 0);
    exp_pulses = exp_pulses - 32'(exp_argmax.size());
    exp_beats.delete();
    exp_argmax.delete();
    held_argmax = 0;
    base = pulses;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_pulse", pulses - base, 0);
    send(3'($urandom), 16'($urandom), 1'b0);
    drain();

    // Input gating: second vector held during STREAM.
    base = pulses;
    send(3'b010, 16'h3012, 1'b1);
    send(3'b000, 16'h0000, 1'b0);
    drain();
    check("gating_pulses", pulses - base, 2);

    // Random vectors with random downstream backpressure.
    rand_ready = 1'b1;
    for (int unsigned v = 0; v < 30; v++) begin
      send(3'($urandom), 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    // Back-to-back throughput.
    base           = beats_seen;
    b2b_mode       = 1'b1;
    last_acc_cycle = 0;
    for (int unsigned v = 0; v < 8; v++) begin
      send(3'($urandom), 16'($urandom), 1'b1);
    end
    in_valid = 1'b0;
    drain();
    b2b_mode = 1'b0;
    check("b2b_beat_count", beats_seen - base, 8 * N);

    check("total_pulses", pulses, exp_pulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
